// File: rtl/hu_dma64_mem_responder.sv
// DMA memory responder: a 64-bit word memory serving one read or write burst at a time.
// A bench backdoor port gives direct access to the memory in parallel with DMA traffic.
module hu_dma64_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dma_read_ctrl_valid,
  output logic          dma_read_ctrl_ready,
  input  logic [31:0]   dma_read_ctrl_data_index,
  input  logic [31:0]   dma_read_ctrl_data_length,
  input  logic [2:0]    dma_read_ctrl_data_size,
  output logic          dma_read_chnl_valid,
  output logic [63:0]   dma_read_chnl_data,
  input  logic          dma_read_chnl_ready,
  input  logic          dma_write_ctrl_valid,
  output logic          dma_write_ctrl_ready,
  input  logic [31:0]   dma_write_ctrl_data_index,
  input  logic [31:0]   dma_write_ctrl_data_length,
  input  logic [2:0]    dma_write_ctrl_data_size,
  input  logic          dma_write_chnl_valid,
  input  logic [63:0]   dma_write_chnl_data,
  output logic          dma_write_chnl_ready,
  input  logic          bd_wr_en,
  input  logic [AW-1:0] bd_addr,
  input  logic [63:0]   bd_wdata,
  output logic [63:0]   bd_rdata,
  output logic          busy,
  output logic [31:0]   rd_beats,
  output logic [31:0]   wr_beats,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   rd_beats_q, rd_beats_d;
  logic [31:0]   wr_beats_q, wr_beats_d;
  logic [63:0]   mem [MEM_WORDS];

  logic rd_hs, wr_hs, rd_beat, wr_beat;
  logic unused_bits;

  // Size codes and index bits above the word address carry no meaning here.
  assign unused_bits = ^{dma_read_ctrl_data_size, dma_write_ctrl_data_size,
                         dma_read_ctrl_data_index[31:AW], dma_write_ctrl_data_index[31:AW]};

  // Every channel transfers exactly when valid and ready are both high at a rising
  // edge; ready/valid are forced low during reset so nothing transfers then.
  always_comb begin
    dma_read_ctrl_ready  = rst && (state_q == IDLE);
    dma_write_ctrl_ready = rst && (state_q == IDLE) && !dma_read_ctrl_valid;
    dma_read_chnl_valid  = rst && (state_q == RD);
    dma_read_chnl_data   = dma_read_chnl_valid ? mem[addr_q] : 64'd0;
    dma_write_chnl_ready = rst && (state_q == WR);
    busy                 = rst && (state_q != IDLE);
    rd_hs                = dma_read_ctrl_valid && dma_read_ctrl_ready;
    wr_hs                = dma_write_ctrl_valid && dma_write_ctrl_ready;
    rd_beat              = dma_read_chnl_valid && dma_read_chnl_ready;
    wr_beat              = dma_write_chnl_valid && dma_write_chnl_ready;
  end

  assign bd_rdata  = mem[bd_addr];
  assign rd_beats  = rd_beats_q;
  assign wr_beats  = wr_beats_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    rd_beats_d = rd_beats_q;
    wr_beats_d = wr_beats_q;
    case (state_q)
      IDLE: begin
        if (rd_hs) begin
          addr_d = dma_read_ctrl_data_index[AW-1:0];
          rem_d  = dma_read_ctrl_data_length;
          if (dma_read_ctrl_data_length != 32'd0) state_d = RD;
        end else if (wr_hs) begin
          addr_d = dma_write_ctrl_data_index[AW-1:0];
          rem_d  = dma_write_ctrl_data_length;
          if (dma_write_ctrl_data_length != 32'd0) state_d = WR;
        end
      end
      RD: begin
        if (rd_beat) begin
          addr_d     = addr_q + ADDR_ONE;
          rem_d      = rem_q - 32'd1;
          rd_beats_d = rd_beats_q + 32'd1;
          if (rem_q == 32'd1) state_d = IDLE;
        end
      end
      WR: begin
        if (wr_beat) begin
          addr_d     = addr_q + ADDR_ONE;
          rem_d      = rem_q - 32'd1;
          wr_beats_d = wr_beats_q + 32'd1;
          if (rem_q == 32'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= 32'd0;
      rd_beats_q <= 32'd0;
      wr_beats_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      rd_beats_q <= rd_beats_d;
      wr_beats_q <= wr_beats_d;
    end
  end

  // Not reset. The DMA write is placed last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (bd_wr_en) mem[bd_addr] <= bd_wdata;
    if (wr_beat)  mem[addr_q]  <= dma_write_chnl_data;
  end

endmodule

// File: tb/tb_hu_dma64_mem_responder.sv
// Randomised bench for hu_dma64_mem_responder: word-array reference model, expected
// read-beat queue drained by an independent monitor, directed corner cases.
module tb_hu_dma64_mem_responder;

  localparam int MW = 1024;
  localparam int AW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          dma_read_ctrl_valid, dma_read_ctrl_ready;
  logic [31:0]   dma_read_ctrl_data_index, dma_read_ctrl_data_length;
  logic [2:0]    dma_read_ctrl_data_size;
  logic          dma_read_chnl_valid, dma_read_chnl_ready;
  logic [63:0]   dma_read_chnl_data;
  logic          dma_write_ctrl_valid, dma_write_ctrl_ready;
  logic [31:0]   dma_write_ctrl_data_index, dma_write_ctrl_data_length;
  logic [2:0]    dma_write_ctrl_data_size;
  logic          dma_write_chnl_valid, dma_write_chnl_ready;
  logic [63:0]   dma_write_chnl_data;
  logic          bd_wr_en;
  logic [AW-1:0] bd_addr;
  logic [63:0]   bd_wdata, bd_rdata;
  logic          busy;
  logic [31:0]   rd_beats, wr_beats;
  logic [1:0]    dbg_state;

  hu_dma64_mem_responder #(.MEM_WORDS(MW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
    .dma_read_ctrl_data_index(dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
    .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_data(dma_read_chnl_data),
    .dma_read_chnl_ready(dma_read_chnl_ready),
    .dma_write_ctrl_valid(dma_write_ctrl_valid), .dma_write_ctrl_ready(dma_write_ctrl_ready),
    .dma_write_ctrl_data_index(dma_write_ctrl_data_index),
    .dma_write_ctrl_data_length(dma_write_ctrl_data_length),
    .dma_write_ctrl_data_size(dma_write_ctrl_data_size),
    .dma_write_chnl_valid(dma_write_chnl_valid), .dma_write_chnl_data(dma_write_chnl_data),
    .dma_write_chnl_ready(dma_write_chnl_ready),
    .bd_wr_en(bd_wr_en), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata),
    .busy(busy), .rd_beats(rd_beats), .wr_beats(wr_beats), .dbg_state(dbg_state)
  );

  // ---------------- model / scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] model [MW];
  logic [63:0] exp_q [$];
  int          beat_cyc [$];
  int          cyc = 0;
  int          hs_cyc = 0;
  bit          bp_en = 1'b0;
  logic [31:0] exp_rd = 32'd0;
  logic [31:0] exp_wr = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Read-channel sink: random backpressure when enabled.
  initial begin
    dma_read_chnl_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dma_read_chnl_ready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: consumes read beats and checks hold-while-stalled.
  initial begin
    logic        hold_v;
    logic [63:0] hold_d;
    hold_v = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("rd_hold_valid", {63'd0, dma_read_chnl_valid}, 64'd1);
          chk("rd_hold_data", dma_read_chnl_data, hold_d);
        end
        if (dma_read_chnl_valid && dma_read_chnl_ready) begin
          beat_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected got %h expected none", dma_read_chnl_data);
          end else begin
            chk("rd_data", dma_read_chnl_data, exp_q.pop_front());
          end
        end
        hold_v = dma_read_chnl_valid && !dma_read_chnl_ready;
        hold_d = dma_read_chnl_data;
      end
    end
  end

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic bd_write(input int a, input logic [63:0] d);
    bd_wr_en = 1'b1;
    bd_addr  = AW'(a);
    bd_wdata = d;
    @(posedge clk);
    #1;
    bd_wr_en = 1'b0;
    model[a & (MW - 1)] = d;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) timeout("wait_idle");
  endtask

  task automatic read_req(input logic [31:0] idx, input logic [31:0] len, input bit bp, input bit coll);
    int n = 0;
    logic [63:0] d;
    bp_en = bp;
    for (int k = 0; k < int'(len); k++) exp_q.push_back(model[(idx + k) & (MW - 1)]);
    dma_read_ctrl_valid       = 1'b1;
    dma_read_ctrl_data_index  = idx;
    dma_read_ctrl_data_length = len;
    dma_read_ctrl_data_size   = 3'($urandom_range(0, 7));
    @(negedge clk);
    while (!dma_read_ctrl_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout("rd_ctrl_ready");
    @(posedge clk);
    #1;
    dma_read_ctrl_valid = 1'b0;
    hs_cyc = cyc;
    if (coll) begin
      d = {$urandom, $urandom};
      bd_write(int'(idx & (MW - 1)), d);
    end
    exp_rd += len;
    wait_idle();
    chk("rd_beats", rd_beats, exp_rd);
  endtask

  task automatic write_data(input logic [31:0] idx, input logic [31:0] len, input int gap,
                            input int coll_beat, input bit coll_same);
    int a, b, n;
    logic [63:0] d, bd;
    b = 0;
    bd = '0;
    for (int k = 0; k < int'(len); k++) begin
      a = (idx + k) & (MW - 1);
      d = {$urandom, $urandom};
      dma_write_chnl_valid = 1'b1;
      dma_write_chnl_data  = d;
      if (k == coll_beat) begin
        b = coll_same ? a : ((a + 100) & (MW - 1));
        bd = {$urandom, $urandom};
        bd_wr_en = 1'b1;
        bd_addr  = AW'(b);
        bd_wdata = bd;
      end
      n = 0;
      @(negedge clk);
      while (!dma_write_chnl_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) timeout("wr_chnl_ready");
      @(posedge clk);
      #1;
      dma_write_chnl_valid = 1'b0;
      bd_wr_en = 1'b0;
      if (k == coll_beat) model[b] = bd;
      model[a] = d;
      if (k == 0 && gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    exp_wr += len;
    @(negedge clk);
    chk("busy_fall", {63'd0, busy}, 64'd0);
    chk("wr_beats", wr_beats, exp_wr);
    for (int k = 0; k < int'(len); k++) begin
      a = (idx + k) & (MW - 1);
      bd_addr = AW'(a);
      #1;
      chk("wr_mem", bd_rdata, model[a]);
    end
    if (coll_beat >= 0 && coll_beat < int'(len)) begin
      bd_addr = AW'(b);
      #1;
      chk("bd_coll_mem", bd_rdata, model[b]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_req(input logic [31:0] idx, input logic [31:0] len, input int gap,
                           input int coll_beat, input bit coll_same);
    int n = 0;
    dma_write_ctrl_valid       = 1'b1;
    dma_write_ctrl_data_index  = idx;
    dma_write_ctrl_data_length = len;
    dma_write_ctrl_data_size   = 3'($urandom_range(0, 7));
    @(negedge clk);
    while (!dma_write_ctrl_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout("wr_ctrl_ready");
    @(posedge clk);
    #1;
    dma_write_ctrl_valid = 1'b0;
    write_data(idx, len, gap, coll_beat, coll_same);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst = 1'b0;
    dma_read_ctrl_valid = 1'b0;  dma_read_ctrl_data_index = '0;
    dma_read_ctrl_data_length = '0;  dma_read_ctrl_data_size = '0;
    dma_write_ctrl_valid = 1'b0; dma_write_ctrl_data_index = '0;
    dma_write_ctrl_data_length = '0; dma_write_ctrl_data_size = '0;
    dma_write_chnl_valid = 1'b0; dma_write_chnl_data = '0;
    bd_wr_en = 1'b0; bd_addr = '0; bd_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_ctrl_ready", {63'd0, dma_read_ctrl_ready}, 64'd0);
    chk("rst_wr_ctrl_ready", {63'd0, dma_write_ctrl_ready}, 64'd0);
    chk("rst_rd_valid", {63'd0, dma_read_chnl_valid}, 64'd0);
    chk("rst_rd_data", dma_read_chnl_data, 64'd0);
    chk("rst_wr_chnl_ready", {63'd0, dma_write_chnl_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_rd_ready", {63'd0, dma_read_ctrl_ready}, 64'd1);
    chk("post_rst_wr_ready", {63'd0, dma_write_ctrl_ready}, 64'd1);
    chk("post_rst_rd_beats", rd_beats, 64'd0);
    chk("post_rst_wr_beats", wr_beats, 64'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < MW; i++) bd_write(i, {$urandom, $urandom});

    // Basic read with ready held high: beats on consecutive cycles.
    for (int i = 0; i < 8; i++) bd_write(i, 64'(i) * 64'h0101);
    beat_cyc.delete();
    read_req(32'd2, 32'd4, 1'b0, 1'b0);
    chk("basic_beat_count", beat_cyc.size(), 64'd4);
    for (int k = 0; k < 4 && k < beat_cyc.size(); k++) chk("basic_beat_cycle", beat_cyc[k], hs_cyc + k);

    // Write with a 2-cycle valid gap after the first beat.
    write_req(32'd5, 32'd3, 2, -1, 1'b0);

    // Simultaneous requests: read first, write one IDLE cycle after the read ends.
    bp_en = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) exp_q.push_back(model[100 + k]);
    dma_read_ctrl_valid = 1'b1;  dma_read_ctrl_data_index = 32'd100;  dma_read_ctrl_data_length = 32'd3;
    dma_write_ctrl_valid = 1'b1; dma_write_ctrl_data_index = 32'd200; dma_write_ctrl_data_length = 32'd2;
    @(negedge clk);
    chk("sim_rd_ready", {63'd0, dma_read_ctrl_ready}, 64'd1);
    chk("sim_wr_ready", {63'd0, dma_write_ctrl_ready}, 64'd0);
    @(posedge clk);
    #1;
    dma_read_ctrl_valid = 1'b0;
    hs_cyc = cyc;
    exp_rd += 32'd3;
    n = 0;
    @(negedge clk);
    while (!dma_write_ctrl_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout("sim_wr_ctrl_ready");
    @(posedge clk);
    #1;
    dma_write_ctrl_valid = 1'b0;
    chk("sim_wr_accept_cycle", cyc, hs_cyc + 4);
    write_data(32'd200, 32'd2, 0, -1, 1'b0);
    chk("sim_rd_beats", rd_beats, exp_rd);

    // Wrap, aliasing, zero length.
    read_req(MW - 2, 32'd4, 1'b0, 1'b0);
    read_req(32'hABCD_0000 | 32'd12, 32'd3, 1'b1, 1'b0);
    write_req(32'h8000_03FF, 32'd3, 1, -1, 1'b0);
    read_req(32'd5, 32'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("zero_len_valid", {63'd0, dma_read_chnl_valid}, 64'd0);
      chk("zero_len_busy", {63'd0, busy}, 64'd0);
    end
    @(posedge clk);
    #1;
    write_req(32'd9, 32'd0, 0, -1, 1'b0);

    // Backdoor collisions: same address (DMA wins), different address (both land),
    // and read-before-write on a read beat.
    write_req(32'd20, 32'd2, 0, 0, 1'b1);
    write_req(32'd40, 32'd2, 0, 1, 1'b0);
    read_req(32'd60, 32'd1, 1'b0, 1'b1);
    bd_addr = AW'(60);
    #1;
    chk("rbw_mem", bd_rdata, model[60]);
    @(posedge clk);
    #1;

    // Reset after beat 2 of an 8-beat read.
    bp_en = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back(model[300]);
    exp_q.push_back(model[301]);
    dma_read_ctrl_valid = 1'b1; dma_read_ctrl_data_index = 32'd300; dma_read_ctrl_data_length = 32'd8;
    @(negedge clk);
    chk("rstmid_ctrl_ready", {63'd0, dma_read_ctrl_ready}, 64'd1);
    @(posedge clk);
    #1;
    dma_read_ctrl_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_valid", {63'd0, dma_read_chnl_valid}, 64'd0);
    chk("rstmid_data", dma_read_chnl_data, 64'd0);
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    chk("rstmid_rd_ready", {63'd0, dma_read_ctrl_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_rd = 32'd0;
    exp_wr = 32'd0;
    @(negedge clk);
    chk("rstmid_after_valid", {63'd0, dma_read_chnl_valid}, 64'd0);
    chk("rstmid_after_busy", {63'd0, busy}, 64'd0);
    chk("rstmid_rd_beats", rd_beats, 64'd0);
    chk("rstmid_wr_beats", wr_beats, 64'd0);
    for (int k = 300; k < 308; k++) begin
      bd_addr = AW'(k);
      #1;
      chk("rstmid_mem", bd_rdata, model[k]);
    end
    @(posedge clk);
    #1;
    read_req(32'd302, 32'd1, 1'b0, 1'b0);

    // Random mix against the word-array model.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0: read_req($urandom, 32'($urandom_range(0, 10)), ($urandom_range(0, 1) == 1), 1'b0);
        1: write_req($urandom, 32'($urandom_range(0, 10)), int'($urandom_range(0, 2)), -1, 1'b0);
        default: bd_write(int'($urandom_range(0, MW - 1)), {$urandom, $urandom});
      endcase
    end

    repeat (4) @(posedge clk);
    chk("exp_q_empty", exp_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hu_dma64_mem_responder.md
HU_DMA64_MEM_RESPONDER -- requirements
Module: hu_dma64_mem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 1024: number of 64-bit words in the internal memory; SHALL be a power of two.
REQ-002 Parameter AW, default 10: memory word-address width, equal to log2(MEM_WORDS).
REQ-003 clk  in  1  single clock; all state SHALL change on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 dma_read_ctrl_valid / _ready  in / out  1 / 1  read-request handshake.
REQ-006 dma_read_ctrl_data_index / _length / _size  in  32 / 32 / 3  start word, beat count, size code.
REQ-007 dma_read_chnl_valid / _data / _ready  out / out / in  1 / 64 / 1  read-data beat handshake.
REQ-008 dma_write_ctrl_valid / _ready  in / out  1 / 1  write-request handshake.
REQ-009 dma_write_ctrl_data_index / _length / _size  in  32 / 32 / 3  start word, beat count, size code.
REQ-010 dma_write_chnl_valid / _data / _ready  in / in / out  1 / 64 / 1  write-data beat handshake.
REQ-011 bd_wr_en / bd_addr / bd_wdata  in  1 / AW / 64  bench backdoor write.
REQ-012 bd_rdata  out  64  combinational mem[bd_addr].
REQ-013 busy  out  1  high whenever the FSM is not in IDLE.
REQ-014 rd_beats / wr_beats  out  32 / 32  cumulative count of completed beats.

Function
REQ-015 FSM states SHALL be IDLE, RD and WR, with one transaction in flight at a time.
REQ-016 dma_read_ctrl_ready SHALL be 1 iff the state is IDLE.
REQ-017 dma_write_ctrl_ready SHALL be 1 iff the state is IDLE and dma_read_ctrl_valid is 0, so reads win simultaneous requests.
REQ-018 On a ctrl handshake, the responder SHALL latch addr = index[AW-1:0] and remaining = length; the size code SHALL be ignored.
REQ-019 If the latched length is 0, the FSM SHALL stay in IDLE and issue no beats.
REQ-020 If the latched length is nonzero, the FSM SHALL enter RD or WR on the next cycle.
REQ-021 In RD, dma_read_chnl_valid SHALL be 1 and dma_read_chnl_data SHALL be mem[addr] combinationally, so the first beat is valid one cycle after the ctrl handshake.
REQ-022 In RD, a beat completes when valid and ready are both 1.
REQ-023 In RD, valid and data SHALL be held stable while ready is 0.
REQ-024 In WR, dma_write_chnl_ready SHALL be 1.
REQ-025 In WR, when valid and ready are both 1, mem[addr] <= dma_write_chnl_data.
REQ-026 Per completed beat: addr SHALL increment modulo MEM_WORDS (wrapping from MEM_WORDS-1 to 0), and remaining SHALL decrement.
REQ-027 Per completed beat: rd_beats or wr_beats SHALL increment, wrapping modulo 2^32.
REQ-028 When the last beat (remaining == 1) completes, the FSM SHALL return to IDLE on the next cycle, so back-to-back requests cost one IDLE cycle.
REQ-029 Index bits above AW-1 SHALL be ignored (aliasing).
REQ-030 Outside RD, dma_read_chnl_valid SHALL be 0; outside WR, dma_write_chnl_ready SHALL be 0.
REQ-031 A backdoor write in the same cycle as a DMA write beat to the same address SHALL lose; the DMA data is stored.
REQ-032 A backdoor write to a different address SHALL proceed in parallel.
REQ-033 Backdoor writes SHALL be accepted in every state.
REQ-034 Memory SHALL be read-before-write: a read beat and a backdoor write to the same address in the same cycle returns the old data.

Reset
REQ-035 While rst == 0 at a clock edge: state <= IDLE, and addr, remaining, rd_beats and wr_beats <= 0.
REQ-036 During reset, all ctrl_ready, dma_read_chnl_valid, dma_write_chnl_ready and busy outputs SHALL be 0, and dma_read_chnl_data SHALL be 0.
REQ-037 Reset mid-transaction SHALL abort the transaction without completing it; remaining beats are dropped.
REQ-038 Memory contents SHALL NOT be cleared by reset.
REQ-039 After reset is released, the block SHALL accept a new request in the first cycle.

Verification
REQ-040 Basic read: backdoor mem[i] = i*0x0101 for i = 0..7; read index 2, length 4, ready held at 1 -> beats 0x0202, 0x0303, 0x0404, 0x0505 on 4 consecutive cycles starting 1 cycle after the handshake; rd_beats = 4.
REQ-041 Backpressure and write: write index 5, length 3, data A, B, C, with the write-chnl valid gap of 2 cycles after beat 1 -> bd_rdata at 5, 6, 7 = A, B, C; wr_beats = 3; busy falls 1 cycle after the last beat.
REQ-042 Simultaneous requests: read and write ctrl valid in the same cycle -> read accepted and write_ctrl_ready = 0; write accepted after the read completes plus 1 IDLE cycle.
REQ-043 Wrap and zero length: read index MEM_WORDS-2, length 4 -> beats from words 1022, 1023, 0, 1; a separate request with length 0 -> no chnl valid and busy stays 0.
REQ-044 Reset mid-read: rst low for 1 cycle after beat 2 of an 8-beat read -> chnl valid = 0, state IDLE, counters 0, memory intact; a following 1-beat read returns the correct word.
